// File: rtl/dpram_pkg.sv
// Shared definitions for the dual-port RAM read engine and its RAM instance.
package dpram_pkg;

  // Address width of the shared video/CPU RAM.
  localparam int DPRAM_AW = 14;

  // Reader command states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/dpram_reader_if.sv
// RAM port and output byte stream of the burst reader.
// master = reader side, slave = RAM plus downstream consumer.
interface dpram_reader_if #(
  parameter int AW = dpram_pkg::DPRAM_AW
);
  logic          ram_ce;
  logic          ram_we;
  logic [7:0]    ram_di;
  logic [AW-1:0] ram_a;
  logic [7:0]    ram_do;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_ready;

  modport master (
    output ram_ce, ram_we, ram_di, ram_a, out_data, out_valid,
    input  ram_do, out_ready
  );

  modport slave (
    input  ram_ce, ram_we, ram_di, ram_a, out_data, out_valid,
    output ram_do, out_ready
  );
endinterface

// File: rtl/dpram_reader_byte_fifo.sv
// Small register FIFO of bytes with synchronous clear and combinational head.
module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  output logic [7:0]               dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);
  localparam int PW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Head is forced to zero when empty so stale storage never shows on the port.
  assign dout    = empty ? 8'h00 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping; clear wins over push/pop.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Byte storage write port.
  always_ff @(posedge clock) begin
    // NOTE: the storage array has no reset; validity is tracked by count and
    // the head is masked when empty, so resetting it would only cost flops.
    if (do_push && !clear) mem[wr_ptr] <= din;
  end

  // The reader sizes its issue window so a push never meets a full FIFO.
  overflow_check: assert property (@(posedge clock) disable iff (reset)
    !(push && full && !pop));

endmodule

// File: rtl/dpram_reader.sv
// Burst read engine for one port of the shared dual-port RAM.
// Optional cancel input enabled by defining DPRAM_READER_ABORT_EN.
module dpram_reader
  import dpram_pkg::*;
#(
  parameter int AW    = DPRAM_AW,
  parameter int DEPTH = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] base,
  input  logic [AW:0]   len,
  output logic          busy,
  output logic          done,
`ifdef DPRAM_READER_ABORT_EN
  input  logic          abort,
`endif
  dpram_reader_if.master bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  state_t        state;
  logic [AW-1:0] addr;
  logic [AW-1:0] ram_a_q;
  logic [AW:0]   remain;
  logic          ce_q;
  logic          inflight;
  logic          kill;
  logic          clear;
  logic          push;
  logic          pop;
  logic          space;
  logic          drained;
  logic [CW-1:0] count;
  logic [CW:0]   occupancy;
  logic [7:0]    head;
  logic          empty;
  logic          full;

`ifdef DPRAM_READER_ABORT_EN
  assign kill = abort && ((state == RUN) || (state == DRAIN));
`else
  assign kill = 1'b0;
`endif

  assign bus.ram_ce    = ce_q && !kill;
  assign bus.ram_we    = 1'b0;
  assign bus.ram_di    = 8'h00;
  assign bus.ram_a     = ram_a_q;
  assign bus.out_data  = head;
  assign bus.out_valid = !empty;

  // ram_do is valid the cycle after an issued read; capture it then.
  assign push  = inflight && !kill;
  assign pop   = !empty && bus.out_ready;
  assign clear = ((state == IDLE) && start) || kill;

  // Issue decision for next cycle: bytes already stored, the byte landing at
  // this edge, and the read on the port now must leave room for one more.
  // Pops are ignored, which is conservative but never overflows.
  assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight} + {{CW{1'b0}}, ce_q};
  assign space     = occupancy < (CW+1)'(DEPTH);

  // Empty after this edge with nothing left in flight (ce_q is 0 in DRAIN).
  assign drained = !push && ((count == '0) || ((count == CW'(1)) && pop));

  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .clear (clear),
    .push  (push),
    .din   (bus.ram_do),
    .pop   (pop),
    .dout  (head),
    .count (count),
    .empty (empty),
    .full  (full)
  );

  // Command FSM with registered RAM strobes and status outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      addr     <= '0;
      remain   <= '0;
      ram_a_q  <= '0;
      ce_q     <= 1'b0;
      inflight <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      inflight <= bus.ram_ce;
      ce_q     <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (len == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state   <= RUN;
              ce_q    <= 1'b1;
              ram_a_q <= base;
              addr    <= base + AW'(1);
              remain  <= len - (AW+1)'(1);
            end
          end
        end
        RUN: begin
          if (kill) begin
            state  <= IDLE;
            busy   <= 1'b0;
            remain <= '0;
          end else if (remain == '0) begin
            state <= DRAIN;
          end else if (space) begin
            ce_q    <= 1'b1;
            ram_a_q <= addr;
            addr    <= addr + AW'(1);
            remain  <= remain - (AW+1)'(1);
          end
        end
        DRAIN: begin
          if (kill) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (drained) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dpram_reader.sv
// Directed self-checking bench for dpram_reader.
module tb_dpram_reader;
  import dpram_pkg::*;

  localparam int AW = DPRAM_AW;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base;
  logic [AW:0]   len;
  logic          busy;
  logic          done;
`ifdef DPRAM_READER_ABORT_EN
  logic          abort;
`endif

  dpram_reader_if #(.AW(AW)) bus ();

  dpram_reader #(.AW(AW), .DEPTH(4)) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .base  (base),
    .len   (len),
    .busy  (busy),
    .done  (done),
`ifdef DPRAM_READER_ABORT_EN
    .abort (abort),
`endif
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // RAM model preloaded with d[a] = a[7:0], one-cycle read latency.
  initial bus.ram_do = 8'h00;
  always @(posedge clock) if (bus.ram_ce) bus.ram_do <= bus.ram_a[7:0];

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  int t0    = 0;

  // Event log gathered away from the active edge.
  int          ce_cnt, we_cnt, done_cnt, valid_cnt, first_ce, first_valid, done_cyc;
  logic [AW-1:0] addr_log[$];
  logic [7:0]    byte_log[$];
  int            pop_cyc[$];

  task automatic clear_logs();
    ce_cnt = 0; we_cnt = 0; done_cnt = 0; valid_cnt = 0;
    first_ce = -1; first_valid = -1; done_cyc = -1;
    addr_log.delete(); byte_log.delete(); pop_cyc.delete();
  endtask

  always @(negedge clock) begin
    if (bus.ram_ce) begin
      ce_cnt++;
      addr_log.push_back(bus.ram_a);
      if (first_ce < 0) first_ce = cyc;
    end
    if (bus.ram_we) we_cnt++;
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (bus.out_valid) begin
      valid_cnt++;
      if (first_valid < 0) first_valid = cyc;
    end
    if (bus.out_valid && bus.out_ready) begin
      byte_log.push_back(bus.out_data);
      pop_cyc.push_back(cyc);
    end
  end

  task automatic do_start(input logic [AW-1:0] b, input logic [AW:0] l);
    @(posedge clock); #1;
    start = 1'b1; base = b; len = l; t0 = cyc;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin @(posedge clock); n++; end
    total++;
    if (done_cnt == 0) begin
      bad++; $display("FAIL %s timeout: no done within %0d cycles", name, budget);
    end
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got %b want 0", done); end
    total++; if (bus.ram_ce !== 1'b0) begin bad++; $display("FAIL reset_ce got %b want 0", bus.ram_ce); end
    total++; if (bus.ram_a !== '0) begin bad++; $display("FAIL reset_addr got %h want 0", bus.ram_a); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", bus.out_valid); end
    total++; if (bus.out_data !== 8'h00) begin bad++; $display("FAIL reset_data got %h want 00", bus.out_data); end
    reset = 1'b0;
    repeat (2) @(posedge clock);
  endtask

  task automatic test_burst();
    bus.out_ready = 1'b1;
    clear_logs();
    do_start(14'h0100, 15'd8);
    wait_done("burst", 60);
    total++; if (byte_log.size() != 8) begin bad++; $display("FAIL burst_count got %0d want 8", byte_log.size()); end
    for (int i = 0; i < 8 && i < byte_log.size(); i++) begin
      total++;
      if (byte_log[i] !== 8'(i)) begin bad++; $display("FAIL burst_byte%0d got %h want %h", i, byte_log[i], 8'(i)); end
      total++;
      if (pop_cyc[i] - t0 != 3 + i) begin bad++; $display("FAIL burst_pop_cycle%0d got %0d want %0d", i, pop_cyc[i] - t0, 3 + i); end
    end
    total++; if (first_ce - t0 != 1) begin bad++; $display("FAIL burst_first_ce got %0d want 1", first_ce - t0); end
    total++; if (first_valid - t0 != 3) begin bad++; $display("FAIL burst_first_valid got %0d want 3", first_valid - t0); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL burst_done_count got %0d want 1", done_cnt); end
    total++; if (done_cyc - t0 != 11) begin bad++; $display("FAIL burst_done_cycle got %0d want 11", done_cyc - t0); end
    total++; if (we_cnt != 0) begin bad++; $display("FAIL burst_we got %0d want 0", we_cnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL burst_busy_after got %b want 0", busy); end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] exp_a [4];
    logic [7:0]    exp_d [4];
    exp_a = '{14'h3FFE, 14'h3FFF, 14'h0000, 14'h0001};
    exp_d = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    bus.out_ready = 1'b1;
    clear_logs();
    do_start(14'h3FFE, 15'd4);
    wait_done("wrap", 40);
    total++; if (addr_log.size() != 4) begin bad++; $display("FAIL wrap_ce_count got %0d want 4", addr_log.size()); end
    total++; if (byte_log.size() != 4) begin bad++; $display("FAIL wrap_byte_count got %0d want 4", byte_log.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < addr_log.size()) begin
        total++;
        if (addr_log[i] !== exp_a[i]) begin bad++; $display("FAIL wrap_addr%0d got %h want %h", i, addr_log[i], exp_a[i]); end
      end
      if (i < byte_log.size()) begin
        total++;
        if (byte_log[i] !== exp_d[i]) begin bad++; $display("FAIL wrap_byte%0d got %h want %h", i, byte_log[i], exp_d[i]); end
      end
    end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    clear_logs();
    do_start(14'h0040, 15'd10);
    while (cyc < t0 + 20) @(posedge clock);
    #1;
    total++; if (ce_cnt != 4) begin bad++; $display("FAIL stall_ce_count got %0d want 4", ce_cnt); end
    total++; if (byte_log.size() != 0) begin bad++; $display("FAIL stall_pops got %0d want 0", byte_log.size()); end
    bus.out_ready = 1'b1;
    wait_done("backpressure", 80);
    total++; if (byte_log.size() != 10) begin bad++; $display("FAIL stall_byte_count got %0d want 10", byte_log.size()); end
    for (int i = 0; i < 10 && i < byte_log.size(); i++) begin
      total++;
      if (byte_log[i] !== 8'h40 + 8'(i)) begin bad++; $display("FAIL stall_byte%0d got %h want %h", i, byte_log[i], 8'h40 + 8'(i)); end
    end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL stall_done_count got %0d want 1", done_cnt); end
  endtask

  task automatic test_zero_len();
    bus.out_ready = 1'b1;
    clear_logs();
    do_start(14'h0123, 15'd0);
    @(negedge clock);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL zero_busy_c1 got %b want 1", busy); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL zero_done_c1 got %b want 1", done); end
    repeat (6) @(posedge clock);
    #1;
    total++; if (ce_cnt != 0) begin bad++; $display("FAIL zero_ce got %0d want 0", ce_cnt); end
    total++; if (valid_cnt != 0) begin bad++; $display("FAIL zero_valid got %0d want 0", valid_cnt); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL zero_done_count got %0d want 1", done_cnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL zero_busy_after got %b want 0", busy); end
  endtask

  task automatic test_start_ignored();
    bus.out_ready = 1'b1;
    clear_logs();
    do_start(14'h0300, 15'd6);
    @(posedge clock); #1;
    start = 1'b1; base = 14'h0500; len = 15'd3;
    @(posedge clock); #1;
    start = 1'b0;
    wait_done("start_ignored", 40);
    total++; if (addr_log.size() != 6) begin bad++; $display("FAIL ign_ce_count got %0d want 6", addr_log.size()); end
    for (int i = 0; i < 6 && i < addr_log.size(); i++) begin
      total++;
      if (addr_log[i] !== 14'h0300 + 14'(i)) begin bad++; $display("FAIL ign_addr%0d got %h want %h", i, addr_log[i], 14'h0300 + 14'(i)); end
    end
    total++; if (byte_log.size() != 6) begin bad++; $display("FAIL ign_byte_count got %0d want 6", byte_log.size()); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL ign_done_count got %0d want 1", done_cnt); end
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    bus.out_ready = 1'b1;
    clear_logs();
    do_start(14'h0000, 15'd16);
    for (int n = 0; n < 20 && !found; n++) begin
      @(negedge clock);
      if (bus.out_valid && bus.out_data == 8'h02) found = 1'b1;
    end
    total++; if (!found) begin bad++; $display("FAIL rst_mid_third_byte not seen within 20 cycles"); end
    #1 reset = 1'b1;
    #1;
    clear_logs();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got %b want 0", busy); end
    total++; if (bus.ram_ce !== 1'b0) begin bad++; $display("FAIL rst_mid_ce got %b want 0", bus.ram_ce); end
    total++; if (bus.ram_a !== '0) begin bad++; $display("FAIL rst_mid_addr got %h want 0", bus.ram_a); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid got %b want 0", bus.out_valid); end
    total++; if (bus.out_data !== 8'h00) begin bad++; $display("FAIL rst_mid_data got %h want 00", bus.out_data); end
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (30) @(posedge clock);
    #1;
    total++; if (done_cnt != 0) begin bad++; $display("FAIL rst_mid_done got %0d want 0", done_cnt); end
    total++; if (ce_cnt != 0) begin bad++; $display("FAIL rst_mid_ce_after got %0d want 0", ce_cnt); end
  endtask

`ifdef DPRAM_READER_ABORT_EN
  task automatic test_abort();
    bus.out_ready = 1'b1;
    clear_logs();
    do_start(14'h0000, 15'd16);
    repeat (2) @(posedge clock);
    #1 abort = 1'b1;
    @(negedge clock);
    total++; if (bus.ram_ce !== 1'b0) begin bad++; $display("FAIL abort_ce got %b want 0", bus.ram_ce); end
    @(posedge clock); #1;
    abort = 1'b0;
    total++; if (dut.state !== IDLE) begin bad++; $display("FAIL abort_state got %0d want IDLE", dut.state); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL abort_valid got %b want 0", bus.out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got %b want 0", busy); end
    repeat (10) @(posedge clock);
    #1;
    total++; if (done_cnt != 0) begin bad++; $display("FAIL abort_done got %0d want 0", done_cnt); end
    clear_logs();
    do_start(14'h0200, 15'd2);
    wait_done("abort_restart", 40);
    total++; if (byte_log.size() != 2) begin bad++; $display("FAIL abort_restart_count got %0d want 2", byte_log.size()); end
    if (byte_log.size() > 0) begin
      total++;
      if (byte_log[0] !== 8'h00) begin bad++; $display("FAIL abort_restart_first got %h want 00", byte_log[0]); end
    end
  endtask
`endif

  initial begin
    start = 1'b0; base = '0; len = '0; bus.out_ready = 1'b0;
`ifdef DPRAM_READER_ABORT_EN
    abort = 1'b0;
`endif
    clear_logs();
    test_reset();
    test_burst();
    test_wrap();
    test_backpressure();
    test_zero_len();
    test_start_ignored();
    test_reset_mid();
`ifdef DPRAM_READER_ABORT_EN
    test_abort();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
